// File: rtl/axi_mux_rr_ctrl.sv
// Packet-aware round-robin arbiter for a select-line AXI-Stream mux.
// Drives the mux select, holds it for a packet or a burst of packets, and gates the mux output stream.
module axi_mux_rr_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SIZE       = 4,
  parameter int unsigned BURST_PKTS = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic [SIZE-1:0]           enable_mask,
  input  logic [SIZE-1:0]           in_tvalid,
  output logic [$clog2(SIZE)-1:0]   select,
  output logic                      grant_active,
  output logic [CNT_W-1:0]          pkt_count,
  input  logic [WIDTH-1:0]          m_tdata,
  input  logic                      m_tlast,
  input  logic                      m_tvalid,
  output logic                      m_tready,
  output logic [WIDTH-1:0]          o_tdata,
  output logic                      o_tlast,
  output logic                      o_tvalid,
  input  logic                      o_tready
);

  localparam int unsigned SEL_W = $clog2(SIZE);
  localparam int unsigned BC_W  = $clog2(BURST_PKTS + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state;
  logic [SEL_W-1:0]  last_grant;
  logic [BC_W-1:0]   burst_cnt;
  logic              in_pkt;

  logic [SIZE-1:0]   req;
  logic [SEL_W-1:0]  winner;
  logic [SEL_W-1:0]  cand;
  logic              found;
  logic              hs;
  logic              eop;
  logic              sel_en;
  logic              sel_valid;
  logic [BC_W-1:0]   burst_nxt;
  logic              burst_done;
  logic              release_grant;

  // Zero-latency gate between mux and consumer
  assign o_tdata  = m_tdata;
  assign o_tlast  = m_tlast;
  assign o_tvalid = m_tvalid & grant_active;
  assign m_tready = o_tready & grant_active;

  assign hs        = m_tvalid & o_tready & grant_active;
  assign eop       = hs & m_tlast;
  assign req       = in_tvalid & enable_mask;
  assign sel_en    = enable_mask[select];
  assign sel_valid = in_tvalid[select];
  assign burst_nxt = burst_cnt + BC_W'(1);
  assign burst_done = eop && (burst_nxt == BC_W'(BURST_PKTS));

  // A disabled or idle input only loses the grant between packets, never mid-packet
  assign release_grant = burst_done
                       || (!sel_en && (eop || (!in_pkt && !hs)))
                       || (!in_pkt && !sel_valid && !hs);

  // Round-robin scan starting one past the previous grant
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 1; k <= SIZE; k++) begin
      cand = SEL_W'((32'(last_grant) + k) % SIZE);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state        <= IDLE;
      select       <= '0;
      last_grant   <= SEL_W'(SIZE - 1);
      burst_cnt    <= '0;
      pkt_count    <= '0;
      grant_active <= 1'b0;
      in_pkt       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            select       <= winner;
            burst_cnt    <= '0;
            in_pkt       <= 1'b0;
            grant_active <= 1'b1;
            state        <= GRANT;
          end
        end
        GRANT: begin
          if (eop) begin
            pkt_count <= pkt_count + CNT_W'(1);
            burst_cnt <= burst_nxt;
          end
          if (hs) begin
            in_pkt <= !m_tlast;
          end
          if (release_grant) begin
            last_grant   <= select;
            grant_active <= 1'b0;
            in_pkt       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          grant_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mux_rr_ctrl.sv
// Bench for axi_mux_rr_ctrl: cycle vector table plus packet-level sequences
// using a behavioural model of the upstream mux and its sources.
module tb_axi_mux_rr_ctrl;

  logic        clk;
  logic        reset;
  logic        clear;
  logic [3:0]  enable_mask;
  logic [3:0]  in_tvalid;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tvalid;
  logic        o_tready;

  logic [1:0]  sel_a, sel_b, sel_x;
  logic        ga_a, ga_b, ga_x;
  logic [7:0]  pc_a, pc_b, pc_x;
  logic        mr_a, mr_b, mr_x;
  logic [31:0] od_a, od_b, od_x;
  logic        ol_a, ol_b, ol_x;
  logic        ov_a, ov_b, ov_x;

  logic        use_b;
  logic        man_mode;
  logic        src_rst;
  logic [3:0]  src_on;
  int          plen [4];
  int          beat [4];
  logic [3:0]  man_tv;
  logic        man_mv, man_ml;
  logic [31:0] man_md;

  int n_chk;
  int n_fail;

  int grants_q[$];
  int beats_q[$];
  int gaps_q[$];
  int lasts_q[$];
  int n_done;
  int idle_run;
  logic ga_prev;
  logic bad_ready;

  axi_mux_rr_ctrl #(.WIDTH(32), .SIZE(4), .BURST_PKTS(1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .clear(clear),
    .enable_mask(enable_mask), .in_tvalid(in_tvalid),
    .select(sel_a), .grant_active(ga_a), .pkt_count(pc_a),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(mr_a),
    .o_tdata(od_a), .o_tlast(ol_a), .o_tvalid(ov_a), .o_tready(o_tready)
  );

  axi_mux_rr_ctrl #(.WIDTH(32), .SIZE(4), .BURST_PKTS(2), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .clear(clear),
    .enable_mask(enable_mask), .in_tvalid(in_tvalid),
    .select(sel_b), .grant_active(ga_b), .pkt_count(pc_b),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(mr_b),
    .o_tdata(od_b), .o_tlast(ol_b), .o_tvalid(ov_b), .o_tready(o_tready)
  );

  always #5 clk = ~clk;

  assign sel_x = use_b ? sel_b : sel_a;
  assign ga_x  = use_b ? ga_b  : ga_a;
  assign pc_x  = use_b ? pc_b  : pc_a;
  assign mr_x  = use_b ? mr_b  : mr_a;
  assign od_x  = use_b ? od_b  : od_a;
  assign ol_x  = use_b ? ol_b  : ol_a;
  assign ov_x  = use_b ? ov_b  : ov_a;

  // Upstream model: the mux forwards the selected source
  always_comb begin
    if (man_mode) begin
      in_tvalid = man_tv;
      m_tvalid  = man_mv;
      m_tlast   = man_ml;
      m_tdata   = man_md;
    end else begin
      in_tvalid = src_on;
      m_tvalid  = src_on[sel_x];
      m_tlast   = (beat[sel_x] == plen[sel_x] - 1);
      m_tdata   = {16'(sel_x), 16'(beat[sel_x])};
    end
  end

  always @(posedge clk) begin
    if (src_rst) begin
      for (int i = 0; i < 4; i++) beat[i] <= 0;
    end else if (!man_mode && m_tvalid && mr_x) begin
      beat[sel_x] <= m_tlast ? 0 : beat[sel_x] + 1;
    end
  end

  // Grant monitor, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (ga_x && !ga_prev) begin
        if (n_done > 0) gaps_q.push_back(idle_run);
        grants_q.push_back(int'(sel_x));
        beats_q.push_back(0);
      end
      if (!ga_x && ga_prev) n_done++;
      if (!ga_x) idle_run++;
      else idle_run = 0;
      if (ga_x && m_tvalid && mr_x && beats_q.size() > 0) begin
        beats_q[beats_q.size()-1] = beats_q[beats_q.size()-1] + 1;
        lasts_q.push_back(int'(ol_x));
      end
      if (mr_x && (sel_x == 2'd0 || sel_x == 2'd2)) bad_ready = 1'b1;
      ga_prev = ga_x;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic clear_mon();
    grants_q.delete();
    beats_q.delete();
    gaps_q.delete();
    lasts_q.delete();
    n_done    = 0;
    idle_run  = 0;
    ga_prev   = 1'b0;
    bad_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset   = 1'b1;
    src_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    src_rst = 1'b0;
    clear_mon();
  endtask

  task automatic wait_done(input int n, input int budget, input string nm);
    int cyc;
    cyc = 0;
    while (n_done < n && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, "_completed_grants"}, 64'(n_done >= n), 64'd1);
  endtask

  typedef struct {
    logic [3:0]  en;
    logic [3:0]  tv;
    logic        mv;
    logic        ml;
    logic        ot;
    logic [31:0] md;
    logic        e_ga;
    logic [1:0]  e_sel;
    logic        e_ov;
    logic        e_mr;
    logic [7:0]  e_pc;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int exp_a [5];
    int exp_b [4];
    int cyc;

    clk = 1'b0; reset = 1'b1; clear = 1'b0;
    enable_mask = 4'hF; o_tready = 1'b0;
    use_b = 1'b0; man_mode = 1'b1; src_rst = 1'b1; src_on = 4'h0;
    man_tv = 4'h0; man_mv = 1'b0; man_ml = 1'b0; man_md = '0;
    for (int i = 0; i < 4; i++) plen[i] = 3;
    n_chk = 0; n_fail = 0;
    clear_mon();

    //          en    tv    mv ml ot md            ga sel  ov mr pc
    tbl[0]  = '{4'hF, 4'h0, 0, 0, 0, 32'h0000_0000, 0, 2'd0, 0, 0, 8'd0};
    tbl[1]  = '{4'hF, 4'h4, 0, 0, 1, 32'h1111_0001, 0, 2'd0, 0, 0, 8'd0};
    tbl[2]  = '{4'hF, 4'h4, 1, 1, 0, 32'h2222_0002, 1, 2'd2, 1, 0, 8'd0};
    tbl[3]  = '{4'hF, 4'h4, 1, 1, 1, 32'h3333_0003, 1, 2'd2, 1, 1, 8'd0};
    tbl[4]  = '{4'hF, 4'h9, 1, 0, 1, 32'h4444_0004, 0, 2'd2, 0, 0, 8'd1};
    tbl[5]  = '{4'hF, 4'h9, 0, 0, 1, 32'h5555_0005, 1, 2'd3, 0, 1, 8'd1};
    tbl[6]  = '{4'hF, 4'h1, 0, 0, 1, 32'h6666_0006, 1, 2'd3, 0, 1, 8'd1};
    tbl[7]  = '{4'hF, 4'h1, 1, 0, 1, 32'h7777_0007, 0, 2'd3, 0, 0, 8'd1};
    tbl[8]  = '{4'hE, 4'h1, 1, 0, 1, 32'h8888_0008, 1, 2'd0, 1, 1, 8'd1};
    tbl[9]  = '{4'hE, 4'h0, 1, 1, 1, 32'h9999_0009, 1, 2'd0, 1, 1, 8'd1};
    tbl[10] = '{4'hE, 4'h1, 0, 0, 1, 32'hAAAA_000A, 0, 2'd0, 0, 0, 8'd2};
    tbl[11] = '{4'hE, 4'h1, 0, 0, 1, 32'hBBBB_000B, 0, 2'd0, 0, 0, 8'd2};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; src_rst = 1'b0;

    // Cycle-accurate vectors, manual mux drive
    for (int i = 0; i < 12; i++) begin
      enable_mask = tbl[i].en;
      man_tv = tbl[i].tv; man_mv = tbl[i].mv; man_ml = tbl[i].ml; man_md = tbl[i].md;
      o_tready = tbl[i].ot;
      @(negedge clk);
      chk($sformatf("vec%0d_grant_active", i), 64'(ga_a), 64'(tbl[i].e_ga));
      chk($sformatf("vec%0d_select", i),       64'(sel_a), 64'(tbl[i].e_sel));
      chk($sformatf("vec%0d_o_tvalid", i),     64'(ov_a), 64'(tbl[i].e_ov));
      chk($sformatf("vec%0d_m_tready", i),     64'(mr_a), 64'(tbl[i].e_mr));
      chk($sformatf("vec%0d_pkt_count", i),    64'(pc_a), 64'(tbl[i].e_pc));
      chk($sformatf("vec%0d_o_tdata", i),      64'(od_a), 64'(tbl[i].md));
      chk($sformatf("vec%0d_o_tlast", i),      64'(ol_a), 64'(tbl[i].ml));
      @(posedge clk); #1;
    end

    // Round robin over all inputs, 3-beat packets
    man_mode = 1'b0; use_b = 1'b0; enable_mask = 4'hF; o_tready = 1'b1;
    for (int i = 0; i < 4; i++) plen[i] = 3;
    src_on = 4'hF;
    do_reset();
    wait_done(5, 300, "rr");
    chk("rr_pkt_count", 64'(pc_a), 64'd5);
    exp_a = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_grant%0d_sel", i), 64'(qget(grants_q, i)), 64'(exp_a[i]));
      chk($sformatf("rr_grant%0d_beats", i), 64'(qget(beats_q, i)), 64'd3);
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_gap%0d", i), 64'(qget(gaps_q, i)), 64'd1);
    src_on = 4'h0;

    // Only inputs 1 and 3 enabled
    enable_mask = 4'b1010; src_on = 4'hF;
    do_reset();
    wait_done(4, 300, "mask");
    exp_b = '{1, 3, 1, 3};
    for (int i = 0; i < 4; i++)
      chk($sformatf("mask_grant%0d_sel", i), 64'(qget(grants_q, i)), 64'(exp_b[i]));
    chk("mask_disabled_ready", 64'(bad_ready), 64'd0);
    src_on = 4'h0;

    // Burst of two packets per grant; input 2 sends single-beat packets
    use_b = 1'b1; enable_mask = 4'hF;
    plen[0] = 3; plen[1] = 3; plen[2] = 1; plen[3] = 3;
    src_on = 4'hF;
    do_reset();
    wait_done(4, 400, "burst");
    exp_b = '{0, 1, 2, 3};
    for (int i = 0; i < 4; i++)
      chk($sformatf("burst_grant%0d_sel", i), 64'(qget(grants_q, i)), 64'(exp_b[i]));
    chk("burst_in2_eops", 64'(qget(beats_q, 2)), 64'd2);
    chk("burst_in0_beats", 64'(qget(beats_q, 0)), 64'd6);
    chk("burst_pkt_count", 64'(pc_b), 64'd8);
    src_on = 4'h0;

    // Enable dropped mid-packet with backpressure toggling
    use_b = 1'b0; enable_mask = 4'hF; o_tready = 1'b1;
    for (int i = 0; i < 4; i++) plen[i] = 4;
    src_on = 4'b0011;
    do_reset();
    cyc = 0;
    while (grants_q.size() < 2 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (ga_a) o_tready = ~o_tready;
      if (beats_q.size() > 0 && beats_q[0] >= 2) enable_mask = 4'b1110;
    end
    chk("endrop_second_grant_seen", 64'(grants_q.size() >= 2), 64'd1);
    chk("endrop_first_sel", 64'(qget(grants_q, 0)), 64'd0);
    chk("endrop_beats", 64'(qget(beats_q, 0)), 64'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("endrop_tlast%0d", i), 64'(qget(lasts_q, i)), 64'(i == 3));
    chk("endrop_gap", 64'(qget(gaps_q, 0)), 64'd1);
    chk("endrop_next_sel", 64'(qget(grants_q, 1)), 64'd1);
    src_on = 4'h0; o_tready = 1'b1; enable_mask = 4'hF;

    // Reset in the middle of a packet
    for (int i = 0; i < 4; i++) plen[i] = 4;
    src_on = 4'hF;
    do_reset();
    cyc = 0;
    while (!(beats_q.size() >= 2 && beats_q[1] >= 1) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rstmid_reached", 64'(beats_q.size() >= 2), 64'd1);
    chk("rstmid_pre_count", 64'(pc_a), 64'd1);
    reset = 1'b1; src_rst = 1'b1; src_on = 4'b0001;
    @(posedge clk); #1;
    chk("rstmid_grant_active", 64'(ga_a), 64'd0);
    chk("rstmid_o_tvalid", 64'(ov_a), 64'd0);
    chk("rstmid_select", 64'(sel_a), 64'd0);
    chk("rstmid_pkt_count", 64'(pc_a), 64'd0);
    reset = 1'b0; src_rst = 1'b0;
    clear_mon();
    cyc = 0;
    while (grants_q.size() < 1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rstmid_regrant_sel", 64'(qget(grants_q, 0)), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_mux_rr_ctrl.md
Name: axi_mux_rr_ctrl

Overview:
Packet-aware round-robin arbitration controller that sits directly downstream of the select-line AXI-Stream mux. The mux must be built with SWITCH_ON_LAST=0.
- Watches the per-input tvalid lines and generates the mux select.
- Passes the mux output stream through to the consumer, gated so beats flow only while a grant is active.
- Holds select stable for a whole packet, or a burst of packets, and rotates fairly among enabled inputs.

Parameters:
WIDTH, 32, tdata width of the pass-through stream
SIZE, 4, number of mux inputs; must be >= 2
BURST_PKTS, 1, max packets per grant before re-arbitration; must be >= 1
CNT_W, 8, width of the granted-packet counter

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
clear  input  1  synchronous clear; same effect as reset
enable_mask  input  SIZE  per-input arbitration enable
in_tvalid  input  SIZE  tvalid lines of the mux inputs, monitor only
select  output  $clog2(SIZE)  registered mux select line
grant_active  output  1  high while in GRANT
pkt_count  output  CNT_W  total packets passed since reset/clear; wraps
m_tdata  input  WIDTH  mux output data
m_tlast  input  1  mux output tlast
m_tvalid  input  1  mux output tvalid
m_tready  output  1  ready returned to mux
o_tdata  output  WIDTH  downstream data
o_tlast  output  1  downstream tlast
o_tvalid  output  1  downstream tvalid
o_tready  input  1  downstream ready

Behaviour:
- Reset/clear, synchronous and highest priority:
  - state=IDLE, select=0, last_grant=SIZE-1 (so the first scan starts at input 0).
  - burst_cnt=0, pkt_count=0, grant_active=0.
- Gate:
  - o_tdata=m_tdata and o_tlast=m_tlast, combinational.
  - o_tvalid = m_tvalid & grant_active.
  - m_tready = o_tready & grant_active.
  - Zero-latency pass-through; no buffering.
- Handshake: hs = m_tvalid & o_tready & grant_active. End of packet: eop = hs & m_tlast.
- IDLE:
  - req = in_tvalid & enable_mask.
  - If req != 0: winner = first set bit scanning last_grant+1, last_grant+2, ..., modulo SIZE. Register select<=winner, burst_cnt<=0, go to GRANT; grant_active rises the next cycle.
  - If req == 0: stay in IDLE; select holds its value.
- GRANT:
  - On eop: pkt_count<=pkt_count+1 (wraps at 2^CNT_W), burst_cnt<=burst_cnt+1.
  - Leave for IDLE on eop when burst_cnt+1==BURST_PKTS, or when enable_mask[select]==0, or when in_tvalid[select]==0 in the cycle after eop. Set last_grant<=select on exit.
  - Otherwise stay in GRANT; select is unchanged.
- Select never changes in GRANT. It changes only on the IDLE->GRANT edge.
- Minimum one-cycle bubble (IDLE) between consecutive grants.
- enable_mask deasserted mid-packet: the packet is not aborted; it completes, then the block exits to IDLE.
- Idle-in-GRANT: if the granted input has no valid and no packet is in progress (first beat not yet taken) for 1 cycle, drop to IDLE. A partially sent packet keeps the grant indefinitely.
- Single-beat packets (tlast on first beat) count as one packet.
- Only enabled inputs are ever granted. An input asserting tvalid while disabled is ignored.

Test Plan:
- Reset then in_tvalid=4'b0000 -> select=0, grant_active=0, o_tvalid=0, m_tready=0 for all cycles.
- SIZE=4, BURST_PKTS=1, all inputs continuously valid with 3-beat packets, o_tready=1 -> grant order 0,1,2,3,0; each grant 3 beats; 1 idle cycle between grants; pkt_count=5 after 5 packets.
- enable_mask=4'b1010, all valid -> grants alternate 1,3,1,3; inputs 0 and 2 never receive m_tready.
- BURST_PKTS=2, input 2 sends back-to-back 1-beat packets, others valid -> input 2 holds grant for exactly 2 eops, then select moves to 3.
- enable_mask[select] cleared on beat 2 of a 4-beat packet with o_tready toggling 1,0,1 -> all 4 beats delivered with tlast on the 4th, then IDLE, then the next enabled input is granted.
- Assert reset mid-packet during GRANT -> next cycle grant_active=0, o_tvalid=0, select=0, pkt_count=0. After release with only input 0 valid, input 0 is granted.
